// File: rtl/dcache_line_mover.sv
// Moves whole cache lines between data-RAM port 1 and the memory bus:
// refill (read burst -> RAM) and evict (RAM -> write burst through a 2-entry skid FIFO).
module dcache_line_mover #(
  parameter int WORDS_PER_LINE = 8,
  parameter int RAM_AW         = 11,
  parameter int LINE_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_req_i,
  input  logic              evict_req_i,
  input  logic [LINE_W-1:0] line_idx_i,
  input  logic [31:0]       fill_addr_i,
  input  logic [31:0]       evict_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_req_o,
  output logic [31:0]       mem_rd_addr_o,
  input  logic              mem_rd_accept_i,
  input  logic              mem_rd_valid_i,
  input  logic [31:0]       mem_rd_data_i,
  output logic              mem_wr_valid_o,
  output logic [31:0]       mem_wr_addr_o,
  output logic [31:0]       mem_wr_data_o,
  output logic              mem_wr_last_o,
  input  logic              mem_wr_ready_i,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic [3:0]        ram_wr_o,
  input  logic [31:0]       ram_data_i
);
  localparam int PW = $clog2(WORDS_PER_LINE);
  localparam logic [PW-1:0] LAST_W  = PW'(WORDS_PER_LINE - 1);
  localparam logic [PW:0]   WPL_CNT = (PW+1)'(WORDS_PER_LINE);

  typedef enum logic [2:0] {IDLE, FILL_REQ, FILL_DATA, EV_RD, DONE} state_t;
  state_t state_q, state_d;

  logic [LINE_W-1:0] line_q;
  logic [31:0]       fill_addr_q, evict_addr_q;
  logic              fill_pend_q;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [PW:0]       rd_cnt_q;
  logic              inflight_q, inflight_last_q;
  logic [1:0][31:0]  fifo_data_q;
  logic [1:0]        fifo_last_q;
  logic              fifo_wp_q, fifo_rp_q;
  logic [1:0]        occ_q;

  logic fill_beat, pop, pop_last, rd_issue;

  assign fill_beat = (state_q == FILL_DATA) && mem_rd_valid_i;
  assign pop       = (occ_q != 2'd0) && mem_wr_ready_i;
  assign pop_last  = pop && fifo_last_q[fifo_rp_q];
  // Occupancy is counted after this cycle's pop so a ready sink sees one beat per cycle.
  assign rd_issue  = (state_q == EV_RD) && (rd_cnt_q != WPL_CNT) &&
                     (({1'b0, occ_q} - {2'b0, pop} + {2'b0, inflight_q}) < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    busy_o         = (state_q != IDLE);
    done_o         = (state_q == DONE);
    mem_rd_req_o   = (state_q == FILL_REQ);
    mem_rd_addr_o  = (state_q == FILL_REQ) ? fill_addr_q : 32'd0;
    mem_wr_valid_o = (occ_q != 2'd0);
    mem_wr_addr_o  = evict_addr_q;
    mem_wr_data_o  = fifo_data_q[fifo_rp_q];
    mem_wr_last_o  = (occ_q != 2'd0) && fifo_last_q[fifo_rp_q];
    ram_addr_o     = {line_q, (state_q == FILL_DATA) ? wptr_q : rptr_q};
    ram_data_o     = fill_beat ? mem_rd_data_i : 32'd0;
    ram_wr_o       = fill_beat ? 4'hF : 4'h0;
    case (state_q)
      IDLE:      if (evict_req_i) state_d = EV_RD;
                 else if (fill_req_i) state_d = FILL_REQ;
      FILL_REQ:  if (mem_rd_accept_i) state_d = FILL_DATA;
      FILL_DATA: if (fill_beat && wptr_q == LAST_W) state_d = DONE;
      EV_RD:     if (pop_last) state_d = fill_pend_q ? FILL_REQ : DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q          <= '0;
      fill_addr_q     <= '0;
      evict_addr_q    <= '0;
      fill_pend_q     <= 1'b0;
      wptr_q          <= '0;
      rptr_q          <= '0;
      rd_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q     <= '0;
      fifo_last_q     <= '0;
      fifo_wp_q       <= 1'b0;
      fifo_rp_q       <= 1'b0;
      occ_q           <= '0;
    end else begin
      if (state_q == IDLE && (evict_req_i || fill_req_i)) begin
        line_q       <= line_idx_i;
        fill_addr_q  <= fill_addr_i;
        evict_addr_q <= evict_addr_i;
        fill_pend_q  <= evict_req_i && fill_req_i;
      end
      if (fill_beat) wptr_q <= wptr_q + 1'b1;
      if (rd_issue) begin
        rptr_q   <= rptr_q + 1'b1;
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
      if (pop_last) begin
        rd_cnt_q    <= '0;
        fill_pend_q <= 1'b0;
      end
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue && (rptr_q == LAST_W);
      // RAM data returns one cycle after the read was issued.
      if (inflight_q) begin
        fifo_data_q[fifo_wp_q] <= ram_data_i;
        fifo_last_q[fifo_wp_q] <= inflight_last_q;
        fifo_wp_q              <= ~fifo_wp_q;
      end
      if (pop) fifo_rp_q <= ~fifo_rp_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end
endmodule
